multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS main decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It stalls on a memory-ready handshake and times out hung memory accesses. It traps syscall and illegal opcodes, and emits the same datapath control set (Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JumpSel, RegDst, WriDataSel, ALUOp) plus IR/PC write strobes and status. Sits between the instruction register/memory port and the shared-ALU datapath.

---
 rtl/mips_ctrl_pkg.sv | 52 +++++
 rtl/control_decode.sv | 90 +++++++++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU function codes, register-destination selects and FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_XOR = 6'h26;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JUMP    = 3'd4,
    C_JAL     = 3'd5,
    C_SYSCALL = 3'd6,
    C_ILLEGAL = 3'd7
  } iclass_e;

endpackage

// File: rtl/control_decode.sv
// Combinational decode of the latched opcode/funct into instruction class,
// legality and the datapath selects that stay stable from DECODE to WB.
module control_decode import mips_ctrl_pkg::*; #(
  parameter int OPW    = 6,
  parameter int FW     = 6,
  parameter int ALUOPW = 6
) (
  input  logic [OPW-1:0]    opcode_i,
  input  logic [FW-1:0]     funct_i,
  output logic [2:0]        iclass_o,
  output logic              legal_o,
  output logic              bne_o,
  output logic              jumpsel_o,
  output logic              memtoreg_o,
  output logic              alusrc_o,
  output logic              wrisel_o,
  output logic [1:0]        regdst_o,
  output logic [ALUOPW-1:0] aluop_o
);

  always_comb begin
    iclass_o   = C_ILLEGAL;
    bne_o      = 1'b0;
    jumpsel_o  = 1'b0;
    memtoreg_o = 1'b0;
    alusrc_o   = 1'b0;
    wrisel_o   = 1'b0;
    regdst_o   = RD_RT;
    aluop_o    = '0;
    case (opcode_i)
      OPW'(OP_RTYPE): begin
        aluop_o  = ALUOPW'(funct_i);
        regdst_o = RD_RD;
        case (funct_i)
          FW'(FN_ADD), FW'(FN_SUB), FW'(FN_AND),
          FW'(FN_OR), FW'(FN_SLT):  iclass_o = C_ALU;
          FW'(FN_JR): begin
            iclass_o  = C_JUMP;
            jumpsel_o = 1'b1;
          end
          FW'(FN_SYSCALL):          iclass_o = C_SYSCALL;
          default: begin
            // Unknown funct: keep every select quiet on the way to ERROR.
            aluop_o  = '0;
            regdst_o = RD_RT;
          end
        endcase
      end
      OPW'(OP_LW): begin
        iclass_o   = C_LOAD;
        aluop_o    = ALUOPW'(ALU_ADD);
        alusrc_o   = 1'b1;
        memtoreg_o = 1'b1;
      end
      OPW'(OP_SW): begin
        iclass_o = C_STORE;
        aluop_o  = ALUOPW'(ALU_ADD);
        alusrc_o = 1'b1;
      end
      OPW'(OP_BEQ): begin
        iclass_o = C_BRANCH;
        aluop_o  = ALUOPW'(ALU_SUB);
      end
      OPW'(OP_BNE): begin
        iclass_o = C_BRANCH;
        aluop_o  = ALUOPW'(ALU_SUB);
        bne_o    = 1'b1;
      end
      OPW'(OP_J):   iclass_o = C_JUMP;
      OPW'(OP_JAL): begin
        iclass_o = C_JAL;
        wrisel_o = 1'b1;
        regdst_o = RD_RA;
      end
      OPW'(OP_ADDI): begin
        iclass_o = C_ALU;
        aluop_o  = ALUOPW'(ALU_ADD);
        alusrc_o = 1'b1;
      end
      OPW'(OP_XORI): begin
        iclass_o = C_ALU;
        aluop_o  = ALUOPW'(ALU_XOR);
        alusrc_o = 1'b1;
      end
      default: iclass_o = C_ILLEGAL;
    endcase
    legal_o = (iclass_o != C_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-ready stall, saturating hung-access timeout, and HALT/ERROR traps.
module multicycle_control import mips_ctrl_pkg::*; #(
  parameter int OPW         = 6,
  parameter int FW          = 6,
  parameter int ALUOPW      = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [FW-1:0]     funct,
  input  logic              mem_ready,
  output logic              Jump,
  output logic              Branch,
  output logic              BranchNe,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              MemtoReg,
  output logic              ALUSrc,
  output logic              JumpSel,
  output logic              WriDataSel,
  output logic [1:0]        RegDst,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ir_write,
  output logic              pc_write,
  output logic              retired,
  output logic              halted,
  output logic              err,
  output logic [2:0]        state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OPW-1:0]    op_q;
  logic [FW-1:0]     fn_q;

  logic [2:0]        cls_raw;
  iclass_e           cls;
  logic              legal, dec_bne, dec_jsel, dec_m2r, dec_asrc, dec_wsel;
  logic [1:0]        dec_rdst;
  logic [ALUOPW-1:0] dec_aluop;
  logic              timeout, sel_en;

  control_decode #(.OPW(OPW), .FW(FW), .ALUOPW(ALUOPW)) u_decode (
    .opcode_i   (op_q),
    .funct_i    (fn_q),
    .iclass_o   (cls_raw),
    .legal_o    (legal),
    .bne_o      (dec_bne),
    .jumpsel_o  (dec_jsel),
    .memtoreg_o (dec_m2r),
    .alusrc_o   (dec_asrc),
    .wrisel_o   (dec_wsel),
    .regdst_o   (dec_rdst),
    .aluop_o    (dec_aluop)
  );

  assign cls     = iclass_e'(cls_raw);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    Jump     = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    retired  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        if (!legal)                state_d = S_ERROR;
        else if (cls == C_SYSCALL) state_d = S_HALT;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_ALU:            state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            Branch   = 1'b1;
            BranchNe = dec_bne;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end
          C_JUMP: begin
            Jump    = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL: begin
            Jump     = 1'b1;
            RegWrite = 1'b1;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end
          default:          state_d = S_ERROR;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls == C_LOAD);
        MemWrite = (cls != C_LOAD);
        if (mem_ready) begin
          if (cls == C_LOAD) begin
            state_d = S_WB;
          end else begin
            retired = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        retired  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // Stall count restarts on every state change and saturates at MEM_TIMEOUT.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign sel_en     = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM) || (state_q == S_WB);
  assign MemtoReg   = sel_en & dec_m2r;
  assign ALUSrc     = sel_en & dec_asrc;
  assign JumpSel    = sel_en & dec_jsel;
  assign WriDataSel = sel_en & dec_wsel;
  assign RegDst     = sel_en ? dec_rdst : RD_RT;
  assign ALUOp      = sel_en ? dec_aluop : '0;
  assign halted     = (state_q == S_HALT);
  assign err        = (state_q == S_ERROR);
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_write) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model expands
// each instruction into expected per-cycle outputs; a monitor compares them.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int MT = 4;

  localparam logic [10:0] F_JMP = 11'h400, F_BR  = 11'h200, F_BNE = 11'h100,
                          F_MRD = 11'h080, F_MWR = 11'h040, F_RW  = 11'h020,
                          F_IRW = 11'h010, F_PCW = 11'h008, F_RET = 11'h004,
                          F_HLT = 11'h002, F_ERR = 11'h001;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_JAL = 5,
                 K_SYS = 6, K_ILL = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       mem_ready = 1'b0;
  logic       Jump, Branch, BranchNe, MemRead, MemWrite, RegWrite;
  logic       MemtoReg, ALUSrc, JumpSel, WriDataSel;
  logic [1:0] RegDst;
  logic [5:0] ALUOp;
  logic       ir_write, pc_write, retired, halted, err;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .FW(6), .ALUOPW(6), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .Jump(Jump), .Branch(Branch), .BranchNe(BranchNe), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .JumpSel(JumpSel), .WriDataSel(WriDataSel), .RegDst(RegDst), .ALUOp(ALUOp),
    .ir_write(ir_write), .pc_write(pc_write), .retired(retired), .halted(halted),
    .err(err), .state(state)
  );

  typedef struct {
    logic [2:0]  st;
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [10:0] strb;
    logic [9:0]  sel;
    logic [1:0]  rd;
    logic        chk_sel;
    logic        chk_rd;
  } rec_t;

  rec_t prog[$];
  rec_t exp_q[$];
  rec_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rel = 1'b0;
  bit   term = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state", 32'(state), 32'(mon_e.st));
      check("strobes", 32'({Jump, Branch, BranchNe, MemRead, MemWrite, RegWrite,
                            ir_write, pc_write, retired, halted, err}), 32'(mon_e.strb));
      if (mon_e.chk_sel)
        check("selects", 32'({MemtoReg, ALUSrc, JumpSel, WriDataSel, ALUOp}), 32'(mon_e.sel));
      else
        check("selects_idle", 32'({MemtoReg, ALUSrc, JumpSel, WriDataSel, ALUOp, RegDst}),
              (mon_e.st == S_DECODE) ? 32'({MemtoReg, ALUSrc, JumpSel, WriDataSel, ALUOp, RegDst}) : 32'(0));
      if (mon_e.chk_rd) check("regdst", 32'(RegDst), 32'(mon_e.rd));
    end
  end

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return K_ALU;
          6'h08: return K_J;
          6'h0C: return K_SYS;
          default: return K_ILL;
        endcase
      end
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h08, 6'h0E: return K_ALU;
      default: return K_ILL;
    endcase
  endfunction

  function automatic rec_t mk(logic [2:0] st, logic [10:0] strb);
    rec_t r;
    r.st = st; r.strb = strb;
    r.mr = 1'($urandom_range(0, 1));
    r.op = 6'($urandom); r.fn = 6'($urandom);
    r.sel = '0; r.rd = '0; r.chk_sel = 1'b0; r.chk_rd = 1'b0;
    return r;
  endfunction

  function automatic void terminal(logic [2:0] st);
    for (int i = 0; i < 3; i++) prog.push_back(mk(st, (st == S_HALT) ? F_HLT : F_ERR));
    term = 1'b1;
  endfunction

  // Expand one instruction into its expected cycles, given the number of
  // not-ready cycles memory inserts in FETCH (sf) and MEM (sm).
  function automatic void build(logic [5:0] op, logic [5:0] fn, int sf, int sm);
    int k;
    logic [5:0] alu;
    logic [9:0] sel;
    logic [1:0] rd;
    rec_t r;
    k = kind_of(op, fn);
    alu = 6'h00;
    if (op == 6'h00)                                   alu = fn;
    else if (op == 6'h23 || op == 6'h2B || op == 6'h08) alu = 6'h20;
    else if (op == 6'h04 || op == 6'h05)               alu = 6'h22;
    else if (op == 6'h0E)                              alu = 6'h26;
    sel = {k == K_LW, (op == 6'h23 || op == 6'h2B || op == 6'h08 || op == 6'h0E),
           (op == 6'h00 && fn == 6'h08), op == 6'h03, alu};
    rd = (op == 6'h00) ? 2'b01 : (op == 6'h03) ? 2'b10 : 2'b00;

    for (int i = 0; i < ((sf > MT) ? MT + 1 : sf); i++) begin
      r = mk(S_FETCH, F_MRD); r.mr = 1'b0; prog.push_back(r);
    end
    if (sf > MT) begin terminal(S_ERROR); return; end
    r = mk(S_FETCH, F_MRD | F_IRW | F_PCW); r.mr = 1'b1; r.op = op; r.fn = fn;
    prog.push_back(r);

    r = mk(S_DECODE, '0);
    if (k != K_ILL) begin r.sel = sel; r.chk_sel = 1'b1; end
    prog.push_back(r);
    if (k == K_SYS) begin terminal(S_HALT); return; end
    if (k == K_ILL) begin terminal(S_ERROR); return; end

    r = mk(S_EXEC, '0); r.sel = sel; r.chk_sel = 1'b1;
    if (k == K_BR)  r.strb = F_BR | ((op == 6'h05) ? F_BNE : 11'h0) | F_RET;
    if (k == K_J)   r.strb = F_JMP | F_RET;
    if (k == K_JAL) begin r.strb = F_JMP | F_RW | F_RET; r.rd = rd; r.chk_rd = 1'b1; end
    prog.push_back(r);
    if (k == K_BR || k == K_J || k == K_JAL) return;

    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < ((sm > MT) ? MT + 1 : sm); i++) begin
        r = mk(S_MEM, (k == K_LW) ? F_MRD : F_MWR); r.mr = 1'b0;
        r.sel = sel; r.chk_sel = 1'b1; prog.push_back(r);
      end
      if (sm > MT) begin terminal(S_ERROR); return; end
      r = mk(S_MEM, (k == K_LW) ? F_MRD : (F_MWR | F_RET)); r.mr = 1'b1;
      r.sel = sel; r.chk_sel = 1'b1; prog.push_back(r);
      if (k == K_SW) return;
    end

    r = mk(S_WB, F_RW | F_RET); r.sel = sel; r.chk_sel = 1'b1;
    r.rd = rd; r.chk_rd = 1'b1;
    prog.push_back(r);
  endfunction

  task automatic do_reset();
    rec_t r;
    @(negedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check("async_reset", 32'({state, Jump, Branch, BranchNe, MemRead, MemWrite, RegWrite,
                              ir_write, pc_write, retired, halted, err}),
          32'({S_FETCH, F_MRD}));
    @(posedge clk); #1;
    r = mk(S_FETCH, F_MRD); r.mr = 1'b0;
    mem_ready = r.mr; opcode = r.op; funct = r.fn;
    exp_q.push_back(r);
    rel = 1'b1;
  endtask

  task automatic run(input int abort_at);
    rec_t r;
    for (int i = 0; i < prog.size(); i++) begin
      @(posedge clk); #1;
      if (rel) begin rst_n = 1'b1; rel = 1'b0; end
      r = prog[i];
      mem_ready = r.mr; opcode = r.op; funct = r.fn;
      exp_q.push_back(r);
      if (i == abort_at) break;
    end
    prog.delete();
    if (term || abort_at >= 0) do_reset();
    term = 1'b0;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int sf, input int sm);
    build(op, fn, sf, sm);
    run(-1);
  endtask

  logic [5:0] ops[14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23,
                          6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0E};
  logic [5:0] fns[14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00,
                          6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    instr(6'h00, 6'h20, 0, 0);   // add
    instr(6'h23, 6'h00, 0, 3);   // lw with three memory stall cycles
    instr(6'h03, 6'h00, 0, 0);   // jal
    instr(6'h2B, 6'h00, 2, 1);   // sw
    instr(6'h04, 6'h00, 1, 0);   // beq
    instr(6'h05, 6'h00, 0, 0);   // bne
    instr(6'h02, 6'h00, 0, 0);   // j
    instr(6'h00, 6'h08, 0, 0);   // jr
    instr(6'h08, 6'h00, 0, 0);   // addi
    instr(6'h0E, 6'h00, 0, 0);   // xori
    instr(6'h00, 6'h2A, MT, 0);  // ready on the timeout cycle wins
    instr(6'h23, 6'h00, 0, MT);
    instr(6'h00, 6'h0C, 0, 0);   // syscall -> HALT
    instr(6'h3F, 6'h00, 0, 0);   // illegal opcode -> ERROR
    instr(6'h00, 6'h01, 0, 0);   // illegal funct -> ERROR
    instr(6'h00, 6'h20, MT + 1, 0);  // FETCH timeout
    instr(6'h2B, 6'h00, 0, MT + 1);  // MEM timeout
    build(6'h00, 6'h22, 0, 0);       // sub aborted by reset during WB
    run(3);
    instr(6'h00, 6'h25, 0, 0);
    for (int n = 0; n < 150; n++) begin
      int pick, sf, sm;
      pick = $urandom_range(0, 29);
      sf = ($urandom_range(0, 24) == 0) ? MT + 1 : $urandom_range(0, 3);
      sm = ($urandom_range(0, 24) == 0) ? MT + 1 : $urandom_range(0, 3);
      if (pick == 29)      instr(6'h00, 6'h0C, sf, sm);
      else if (pick == 28) instr(6'h3F, 6'($urandom), sf, sm);
      else if (pick == 27) instr(6'h00, 6'h3F, sf, sm);
      else                 instr(ops[pick % 14], fns[pick % 14], sf, sm);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
